// File: rtl/decode_pkg.sv
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared types, opcodes and field positions for the decode stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    // Widths baked into the ID/EX record; the stage's defaults match these.
    localparam int ID_DATA_W = 24;
    localparam int ID_RW     = 4;

    typedef enum logic [1:0] {
        ARITH_R = 2'b00,
        ARITH_I = 2'b01,
        MEM     = 2'b10,
        BRANCH  = 2'b11
    } inst_type_e;

    localparam logic [3:0] OP_LD = 4'b0000;
    localparam logic [3:0] OP_ST = 4'b0001;

    localparam int TYPE_LO = 30;
    localparam int OP_LO   = 26;
    localparam int RD_LO   = 22;
    localparam int RA_LO   = 18;
    localparam int RB_LO   = 14;

    typedef struct packed {
        logic                 valid;
        inst_type_e           itype;
        logic [3:0]           op;
        logic [ID_RW-1:0]     rd;
        logic [ID_RW-1:0]     ra;
        logic [ID_RW-1:0]     rb;
        logic [ID_DATA_W-1:0] rd_val;
        logic [ID_DATA_W-1:0] ra_val;
        logic [ID_DATA_W-1:0] rb_val;
        logic [ID_DATA_W-1:0] imm;
        logic [ID_DATA_W-1:0] pc;
        logic                 reg_we;
        logic                 mem_rd;
        logic                 mem_wr;
        logic                 branch;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/decode_stage_hz_reg_file.sv
// ============================================================================
// Module   : reg_file
// Purpose  : 3-read / 1-write register file with same-cycle write bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter  int DATA_W = 24,
    parameter  int NREG   = 16,
    localparam int RW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RW-1:0]     rd_idx_a,
    input  logic [RW-1:0]     rd_idx_b,
    input  logic [RW-1:0]     rd_idx_c,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c
);

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // A write in the same cycle is visible to readers immediately.
    assign rd_data_a = (we && (wr_idx == rd_idx_a)) ? wr_data : r_mem[rd_idx_a];
    assign rd_data_b = (we && (wr_idx == rd_idx_b)) ? wr_data : r_mem[rd_idx_b];
    assign rd_data_c = (we && (wr_idx == rd_idx_c)) ? wr_data : r_mem[rd_idx_c];

endmodule

`default_nettype wire

// File: rtl/decode_stage_hz.sv
// ============================================================================
// Module   : decode_stage_hz
// Purpose  : Decode stage with register file, load-use stall and ID/EX register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_stage_hz
    import decode_pkg::*;
#(
    parameter  int DATA_W = 24,
    parameter  int INST_W = 32,
    parameter  int NREG   = 16,
    parameter  int IMM_W  = 18,
    parameter  int CNT_W  = 16,
    localparam int RW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic [INST_W-1:0] inst,
    input  logic [DATA_W-1:0] pc,
    input  logic              WE,
    input  logic [RW-1:0]     Rd,
    input  logic [DATA_W-1:0] WD,
    output logic              stall,
    output logic              ex_valid,
    output logic [1:0]        ex_type,
    output logic [3:0]        ex_op,
    output logic [RW-1:0]     ex_rd,
    output logic [RW-1:0]     ex_ra,
    output logic [RW-1:0]     ex_rb,
    output logic [DATA_W-1:0] ex_rd_val,
    output logic [DATA_W-1:0] ex_ra_val,
    output logic [DATA_W-1:0] ex_rb_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_branch,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    inst_type_e        w_type;
    logic [3:0]        w_op;
    logic [RW-1:0]     w_rd;
    logic [RW-1:0]     w_ra;
    logic [RW-1:0]     w_rb;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_ra_val;
    logic [DATA_W-1:0] w_rb_val;
    logic [DATA_W-1:0] w_imm;
    logic              w_nop;
    logic              w_is_ld;
    logic              w_is_st;
    logic              w_dec_valid;
    logic              w_uses_regs;
    logic              w_hz;
    id_ex_t            w_dec;
    id_ex_t            r_ex;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_type = inst_type_e'(inst[TYPE_LO +: 2]);
    assign w_op   = inst[OP_LO +: 4];
    assign w_rd   = inst[RD_LO +: RW];
    assign w_ra   = inst[RA_LO +: RW];
    assign w_rb   = inst[RB_LO +: RW];

    reg_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .we        (WE),
        .wr_idx    (Rd),
        .wr_data   (WD),
        .rd_idx_a  (w_ra),
        .rd_idx_b  (w_rb),
        .rd_idx_c  (w_rd),
        .rd_data_a (w_ra_val),
        .rd_data_b (w_rb_val),
        .rd_data_c (w_rd_val)
    );

    // Branch offsets are signed; every other immediate is unsigned.
    assign w_imm = (w_type == BRANCH)
                 ? {{(DATA_W-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]}
                 : {{(DATA_W-IMM_W){1'b0}},          inst[IMM_W-1:0]};

    always_comb begin
        w_nop       = (inst == '0);
        w_is_ld     = (w_type == MEM) && (w_op == OP_LD);
        w_is_st     = (w_type == MEM) && (w_op == OP_ST);
        w_dec_valid = !w_nop && ((w_type != MEM) || w_is_ld || w_is_st);
        w_uses_regs = !w_nop && (w_type != BRANCH);
        w_hz        = r_ex.valid && r_ex.mem_rd && w_uses_regs &&
                      ((r_ex.rd == w_ra) || (r_ex.rd == w_rb) ||
                       (w_is_st && (r_ex.rd == w_rd)));
        stall       = w_hz && !flush;
    end

    always_comb begin
        w_dec = '0;
        if (w_dec_valid) begin
            w_dec.valid  = 1'b1;
            w_dec.itype  = w_type;
            w_dec.op     = w_op;
            w_dec.rd     = w_rd;
            w_dec.ra     = w_ra;
            w_dec.rb     = w_rb;
            w_dec.rd_val = w_rd_val;
            w_dec.ra_val = w_ra_val;
            w_dec.rb_val = w_rb_val;
            w_dec.imm    = w_imm;
            w_dec.pc     = pc;
            w_dec.reg_we = (w_type == ARITH_R) || (w_type == ARITH_I) || w_is_ld;
            w_dec.mem_rd = w_is_ld;
            w_dec.mem_wr = w_is_st;
            w_dec.branch = (w_type == BRANCH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_stall_cnt <= '0;
        end else if (en) begin
            if (flush || stall) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_dec;
            end
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
        end
    end

    assign ex_valid  = r_ex.valid;
    assign ex_type   = r_ex.itype;
    assign ex_op     = r_ex.op;
    assign ex_rd     = r_ex.rd;
    assign ex_ra     = r_ex.ra;
    assign ex_rb     = r_ex.rb;
    assign ex_rd_val = r_ex.rd_val;
    assign ex_ra_val = r_ex.ra_val;
    assign ex_rb_val = r_ex.rb_val;
    assign ex_imm    = r_ex.imm;
    assign ex_pc     = r_ex.pc;
    assign ex_reg_we = r_ex.reg_we;
    assign ex_mem_rd = r_ex.mem_rd;
    assign ex_mem_wr = r_ex.mem_wr;
    assign ex_branch = r_ex.branch;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_hz.sv
// ============================================================================
// Module   : tb_decode_stage_hz
// Purpose  : Directed and randomized checks of decode_stage_hz.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_hz;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic [31:0] inst;
    logic [23:0] pc;
    logic        WE;
    logic [3:0]  Rd;
    logic [23:0] WD;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_type;
    logic [3:0]  ex_op;
    logic [3:0]  ex_rd, ex_ra, ex_rb;
    logic [23:0] ex_rd_val, ex_ra_val, ex_rb_val, ex_imm, ex_pc;
    logic        ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage_hz #(
        .DATA_W (24), .INST_W (32), .NREG (16), .IMM_W (18), .CNT_W (16)
    ) dut (
        .clk (clk), .rst (rst), .en (en), .flush (flush), .inst (inst), .pc (pc),
        .WE (WE), .Rd (Rd), .WD (WD), .stall (stall), .ex_valid (ex_valid),
        .ex_type (ex_type), .ex_op (ex_op), .ex_rd (ex_rd), .ex_ra (ex_ra),
        .ex_rb (ex_rb), .ex_rd_val (ex_rd_val), .ex_ra_val (ex_ra_val),
        .ex_rb_val (ex_rb_val), .ex_imm (ex_imm), .ex_pc (ex_pc),
        .ex_reg_we (ex_reg_we), .ex_mem_rd (ex_mem_rd), .ex_mem_wr (ex_mem_wr),
        .ex_branch (ex_branch), .stall_cnt (stall_cnt)
    );

    localparam logic [31:0] LD_R15 = 32'h83C10000;

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] op,
                                       input logic [3:0] rd, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [13:0] lo);
        return {t, op, rd, ra, rb, lo};
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; WE = 1'b0; Rd = '0; WD = '0;
        inst = '0; pc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; WE = 1'b0; Rd = '0; WD = '0;
        inst = LD_R15; pc = 24'h000040;
        #1;
        checks++;
        if ({stall, ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {stall, ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch});
        end
        checks++;
        if ({stall_cnt, ex_pc, ex_imm} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got cnt=%h pc=%h imm=%h want 0", stall_cnt, ex_pc, ex_imm);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset();
        WE = 1'b1; Rd = 4'd5; WD = 24'h000123;
        inst = mk(2'b00, 4'd2, 4'd1, 4'd5, 4'd0, 14'd0);
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, ex_type, ex_reg_we, ex_ra_val} !== {1'b1, 2'b00, 1'b1, 24'h000123}) begin
            errors++;
            $display("FAIL bypass got v=%b type=%b we=%b ra_val=%h want 1 00 1 000123",
                     ex_valid, ex_type, ex_reg_we, ex_ra_val);
        end
        @(negedge clk);
        WE = 1'b0;
        inst = mk(2'b00, 4'd3, 4'd2, 4'd0, 4'd5, 14'd0);
        @(posedge clk); #1;
        checks++;
        if (ex_rb_val !== 24'h000123) begin
            errors++;
            $display("FAIL regfile_persist got rb_val=%h want 000123", ex_rb_val);
        end
    endtask

    task automatic test_imm_decode();
        do_reset();
        inst = 32'h5698000F; pc = 24'h000100;
        @(posedge clk); #1;
        checks++;
        if ({ex_type, ex_op, ex_rd, ex_ra, ex_imm, ex_pc} !==
            {2'b01, 4'b0101, 4'd10, 4'd6, 24'd15, 24'h000100}) begin
            errors++;
            $display("FAIL imm_decode got type=%b op=%b rd=%0d ra=%0d imm=%h pc=%h",
                     ex_type, ex_op, ex_rd, ex_ra, ex_imm, ex_pc);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        inst = LD_R15;
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, ex_mem_rd, ex_reg_we, ex_rd, ex_ra, ex_rb} !== {3'b111, 4'd15, 4'd0, 4'd4}) begin
            errors++;
            $display("FAIL load_decode got v=%b mrd=%b we=%b rd=%0d ra=%0d rb=%0d",
                     ex_valid, ex_mem_rd, ex_reg_we, ex_rd, ex_ra, ex_rb);
        end
        @(negedge clk);
        inst = mk(2'b00, 4'd1, 4'd3, 4'd15, 4'd2, 14'd0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall got %b want 1", stall);
        end
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, stall_cnt} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL load_use_bubble got v=%b cnt=%0d want 0 1", ex_valid, stall_cnt);
        end
        @(negedge clk); #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_release got %b want 0", stall);
        end
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, ex_op, ex_ra, stall_cnt} !== {1'b1, 4'd1, 4'd15, 16'd1}) begin
            errors++;
            $display("FAIL load_use_issue got v=%b op=%0d ra=%0d cnt=%0d want 1 1 15 1",
                     ex_valid, ex_op, ex_ra, stall_cnt);
        end
    endtask

    task automatic test_branch_sext();
        do_reset();
        inst = LD_R15;
        @(posedge clk);
        @(negedge clk);
        inst = mk(2'b11, 4'd0, 4'd15, 4'd15, 4'hF, 14'h3FFE);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL branch_no_stall got %b want 0", stall);
        end
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, ex_branch, ex_reg_we, ex_imm} !== {3'b110, 24'hFFFFFE}) begin
            errors++;
            $display("FAIL branch_sext got v=%b br=%b we=%b imm=%h want 1 1 0 fffffe",
                     ex_valid, ex_branch, ex_reg_we, ex_imm);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        inst = LD_R15;
        @(posedge clk);
        @(negedge clk);
        inst = mk(2'b00, 4'd1, 4'd3, 4'd15, 4'd2, 14'd0);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got %b want 0", stall);
        end
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, stall_cnt} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL flush_bubble got v=%b cnt=%0d want 0 0", ex_valid, stall_cnt);
        end
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, ex_ra} !== {1'b1, 4'd15}) begin
            errors++;
            $display("FAIL flush_refetch got v=%b ra=%0d want 1 15", ex_valid, ex_ra);
        end
    endtask

    task automatic test_en_hold();
        do_reset();
        inst = LD_R15; pc = 24'h000200;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            en = 1'b0;
            inst = mk(2'b10, 4'd1, 4'd15, 4'd1, 4'd1, 14'd0);
            pc = 24'h000204;
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL en_hold_stall cycle %0d got %b want 1", k, stall);
            end
            @(posedge clk); #1;
            checks++;
            if ({ex_valid, ex_mem_rd, ex_rd, ex_pc, stall_cnt} !==
                {2'b11, 4'd15, 24'h000200, 16'd0}) begin
                errors++;
                $display("FAIL en_hold cycle %0d got v=%b mrd=%b rd=%0d pc=%h cnt=%0d",
                         k, ex_valid, ex_mem_rd, ex_rd, ex_pc, stall_cnt);
            end
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, stall_cnt} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL en_resume got v=%b cnt=%0d want 0 1", ex_valid, stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst = LD_R15; pc = 24'h000300; WE = 1'b1; Rd = 4'd15; WD = 24'h000777;
        @(posedge clk);
        @(negedge clk);
        WE = 1'b0;
        inst = mk(2'b00, 4'd4, 4'd2, 4'd15, 4'd3, 14'd9);
        pc = 24'h000304;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_stall got %b want 1", stall);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({stall, ex_valid, ex_mem_rd, ex_reg_we, ex_rd, ex_pc, ex_imm, ex_ra_val, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset got st=%b v=%b mrd=%b we=%b rd=%0d pc=%h cnt=%0d",
                     stall, ex_valid, ex_mem_rd, ex_reg_we, ex_rd, ex_pc, stall_cnt);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, ex_ra, ex_ra_val, ex_pc} !== {1'b1, 4'd15, 24'h0, 24'h000304}) begin
            errors++;
            $display("FAIL async_after got v=%b ra=%0d ra_val=%h pc=%h want 1 15 000000 000304",
                     ex_valid, ex_ra, ex_ra_val, ex_pc);
        end
    endtask

    task automatic test_random(input int n);
        logic [23:0] m_regs [16];
        logic        e_valid, e_we, e_mrd, e_mwr, e_br, x_stall;
        logic [1:0]  e_type, t;
        logic [3:0]  e_op, e_rd, e_ra, e_rb, op, rd, ra, rb;
        logic [23:0] e_rdv, e_rav, e_rbv, e_imm, e_pc;
        logic [15:0] e_cnt;
        logic        nop, is_ld, is_st, dec_ok;
        do_reset();
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        e_valid = 0; e_we = 0; e_mrd = 0; e_mwr = 0; e_br = 0; e_cnt = '0;
        e_type = '0; e_op = '0; e_rd = '0; e_ra = '0; e_rb = '0;
        e_rdv = '0; e_rav = '0; e_rbv = '0; e_imm = '0; e_pc = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            WE    = 1'($urandom_range(0, 1));
            Rd    = 4'($urandom_range(0, 15));
            WD    = 24'($urandom);
            pc    = 24'($urandom);
            t     = 2'($urandom_range(0, 3));
            op    = (t == 2'b10 && $urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 1))
                                                              : 4'($urandom_range(0, 15));
            rd    = 4'($urandom_range(12, 15));
            ra    = 4'($urandom_range(10, 15));
            rb    = 4'($urandom_range(10, 15));
            inst  = ($urandom_range(0, 15) == 0) ? 32'h0 : mk(t, op, rd, ra, rb, 14'($urandom));
            #1;
            t = inst[31:30]; op = inst[29:26]; rd = inst[25:22]; ra = inst[21:18]; rb = inst[17:14];
            nop    = (inst == 32'h0);
            is_ld  = (t == 2'b10) && (op == 4'd0);
            is_st  = (t == 2'b10) && (op == 4'd1);
            dec_ok = !nop && !(t == 2'b10 && op > 4'd1);
            x_stall = e_valid && e_mrd && !nop && (t != 2'b11) && !flush &&
                      (e_rd == ra || e_rd == rb || (is_st && e_rd == rd));
            checks++;
            if (stall !== x_stall) begin
                errors++;
                $display("FAIL rand_stall iter %0d inst=%h got %b want %b", i, inst, stall, x_stall);
            end
            @(posedge clk);
            if (en) begin
                if (x_stall && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
                if (flush || x_stall || !dec_ok) begin
                    e_valid = 0; e_we = 0; e_mrd = 0; e_mwr = 0; e_br = 0;
                end else begin
                    e_valid = 1; e_type = t; e_op = op; e_rd = rd; e_ra = ra; e_rb = rb;
                    e_rdv = (WE && Rd == rd) ? WD : m_regs[rd];
                    e_rav = (WE && Rd == ra) ? WD : m_regs[ra];
                    e_rbv = (WE && Rd == rb) ? WD : m_regs[rb];
                    e_imm = (t == 2'b11) ? {{6{inst[17]}}, inst[17:0]} : {6'b0, inst[17:0]};
                    e_pc  = pc;
                    e_we  = (t == 2'b00) || (t == 2'b01) || is_ld;
                    e_mrd = is_ld; e_mwr = is_st; e_br = (t == 2'b11);
                end
            end
            if (WE) m_regs[Rd] = WD;
            #1;
            checks++;
            if ({ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, stall_cnt} !==
                {e_valid, e_we, e_mrd, e_mwr, e_br, e_cnt}) begin
                errors++;
                $display("FAIL rand_ctrl iter %0d got v/we/rd/wr/br=%b%b%b%b%b cnt=%0d want %b%b%b%b%b cnt=%0d",
                         i, ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, stall_cnt,
                         e_valid, e_we, e_mrd, e_mwr, e_br, e_cnt);
            end
            if (e_valid) begin
                checks++;
                if ({ex_type, ex_op, ex_rd, ex_ra, ex_rb, ex_rd_val, ex_ra_val, ex_rb_val, ex_imm, ex_pc} !==
                    {e_type, e_op, e_rd, e_ra, e_rb, e_rdv, e_rav, e_rbv, e_imm, e_pc}) begin
                    errors++;
                    $display("FAIL rand_fields iter %0d got %h/%h/%h/%h/%h vals %h %h %h imm %h pc %h want %h/%h/%h/%h/%h vals %h %h %h imm %h pc %h",
                             i, ex_type, ex_op, ex_rd, ex_ra, ex_rb, ex_rd_val, ex_ra_val, ex_rb_val, ex_imm, ex_pc,
                             e_type, e_op, e_rd, e_ra, e_rb, e_rdv, e_rav, e_rbv, e_imm, e_pc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_imm_decode();
        test_load_use();
        test_branch_sext();
        test_flush_hazard();
        test_en_hold();
        test_async_reset();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
Parametrised instruction-decode stage for the 24-bit pipelined core. It holds the register file, decodes fields and immediates, and owns the ID/EX pipeline register. Unlike the previous decode, it detects load-use hazards itself: it stalls upstream and inserts a bubble. It also supports branch flush and keeps a saturating stall counter. It sits between the IF/ID buffer and the execute stage.

Parameters:
DATA_W, 24, register/data width
INST_W, 32, instruction width
NREG, 16, register count (index width RW = clog2(NREG), 4 by default)
IMM_W, 18, immediate field width, inst[IMM_W-1:0]
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
en  in  1  pipeline advance; 0 = ID/EX register holds
flush  in  1  kill the instruction in ID (taken branch)
inst  in  INST_W  instruction from the IF/ID buffer
pc  in  DATA_W  PC of inst
WE  in  1  write-back enable
Rd  in  RW  write-back register index
WD  in  DATA_W  write-back data
stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_type  out  2  00 arith-reg, 01 arith-imm, 10 memory, 11 branch
ex_op  out  4  opcode
ex_rd, ex_ra, ex_rb  out  RW  register indices
ex_rd_val, ex_ra_val, ex_rb_val  out  DATA_W  operand values
ex_imm  out  DATA_W  extended immediate
ex_pc  out  DATA_W  registered PC
ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch  out  1  control bits
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Field layout:
  - type = inst[31:30], op = inst[29:26], rd = inst[25:22], ra = inst[21:18], rb = inst[17:14].
  - imm = inst[IMM_W-1:0], zero-extended for types 00/01/10 and sign-extended for type 11.
- Control:
  - Types 00/01: ex_reg_we = 1.
  - Type 10, op 0000 (load): ex_mem_rd = 1, ex_reg_we = 1.
  - Type 10, op 0001 (store): ex_mem_wr = 1. The data source is rd.
  - Type 11: ex_branch = 1.
  - Any other type-10 opcode decodes as a bubble.
- All-zero instruction is a NOP: it decodes as a bubble (ex_valid = 0, all control bits 0).
- Register file:
  - Three combinational read ports (ra, rb, rd) and one write port on posedge clk when WE = 1.
  - Writes happen regardless of en, stall and flush.
  - Same-cycle bypass: when a read index equals Rd and WE = 1, the read returns WD.
- Load-use hazard (combinational):
  - hz = ex_valid & ex_mem_rd & (ex_rd == ra or ex_rd == rb or (store and ex_rd == rd)).
  - For type 11 and NOP, only the indices the instruction actually uses are compared (branch compares none).
  - stall = hz & ~flush.
- ID/EX update on posedge clk when en = 1, in priority order:
  - flush = 1 → bubble.
  - stall = 1 → bubble.
  - otherwise → load the decoded instruction.
- When en = 0: ID/EX holds its contents, stall is still driven, and the counter does not increment.
- Latency: 1 cycle from inst to the ex_* outputs.
- stall_cnt: increments on each posedge where en & stall, and saturates at all-ones.
- Reset (async, immediate):
  - All registers, ID/EX fields and stall_cnt go to 0; ex_valid = 0.
  - The stall output is therefore 0 right after reset.
  - Reset mid-stall discards the bubble state; the next instruction decodes normally.

Decomposition:
- decode_pkg holds:
  - the type enum (ARITH_R, ARITH_I, MEM, BRANCH);
  - opcode constants OP_LD = 0000 and OP_ST = 0001;
  - field bit positions;
  - a packed struct id_ex_t carrying all ex_* fields.
- Sub-module reg_file (parametrised by DATA_W and NREG; 3R/1W with bypass).

Test Plan:
- Reset, then WE = 1, Rd = 5, WD = 24'h000123, with inst = arith-reg reading ra = 5 in the same cycle → after the posedge, ex_ra_val = 24'h000123, ex_type = 00, ex_reg_we = 1.
- inst = 32'h5698000F (div r10,r6,#15) → next cycle ex_type = 01, ex_op = 0101, ex_rd = 10, ex_ra = 6, ex_imm = 15.
- Load-use: ld r15,[r0+r4] (32'h83C10000), followed by an add that reads ra = 15 →
  - stall = 1 for exactly one cycle;
  - ex_valid = 0 in the following cycle, then the add issues;
  - stall_cnt = 1.
- Same load followed by a branch with imm = 18'h3FFFE → no stall, and ex_imm = 24'hFFFFFE (sign-extended).
- Hazard and flush together: flush = 1 → stall = 0, bubble inserted, stall_cnt unchanged.
- en = 0 for 3 cycles during a hazard → ID/EX is unchanged and stall_cnt is unchanged. Separately, assert rst mid-run → every output is 0 immediately, with no clock edge needed.
